// File: rtl/uart_buffered_if_pkg.sv
// rtl/uart_buffered_if_pkg.sv - shared types and helpers for the buffered UART host interface
//
// Package uart_buf_pkg
//   tx_state_t : TX launch FSM states (IDLE, REQ, WAIT_START, WAIT_DONE)
//   lvl_w()    : width of an occupancy counter able to hold 0..depth
package uart_buf_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_state_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_buffered_if_if.sv
// rtl/uart_buffered_if_if.sv - host-side bundle of the buffered UART interface
//
// Interface uart_host_if
//   master : host/pin side (drives rx_pop, ovr_clr, tx_push, tx_wdata)
//   slave  : uart_buffered_if side (drives RX head/status and TX status)
interface uart_host_if
    import uart_buf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4
);
    localparam int RX_LW = lvl_w(RX_DEPTH);
    localparam int TX_LW = lvl_w(TX_DEPTH);

    logic              rx_pop;
    logic [DATA_W-1:0] rx_data;
    logic              rx_data_err;
    logic              rx_avail;
    logic [RX_LW-1:0]  rx_level;
    logic              rx_overrun;
    logic              ovr_clr;
    logic              tx_push;
    logic [DATA_W-1:0] tx_wdata;
    logic              tx_full;
    logic [TX_LW-1:0]  tx_level;
    logic              tx_active;

    modport master (
        output rx_pop, ovr_clr, tx_push, tx_wdata,
        input  rx_data, rx_data_err, rx_avail, rx_level, rx_overrun,
        input  tx_full, tx_level, tx_active
    );

    modport slave (
        input  rx_pop, ovr_clr, tx_push, tx_wdata,
        output rx_data, rx_data_err, rx_avail, rx_level, rx_overrun,
        output tx_full, tx_level, tx_active
    );

endinterface

// File: rtl/uart_buffered_if_sync_fifo.sv
// rtl/uart_buffered_if_sync_fifo.sv - single-clock show-ahead FIFO with level counter
//
// Module sync_fifo
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write at tail (ignored when full unless a pop happens in the same cycle)
//   pop        : drop head entry (ignored when empty)
//   head       : head entry, zero when empty
//   full/empty : occupancy flags, level : occupancy count 0..DEPTH
module sync_fifo
    import uart_buf_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int LW    = lvl_w(DEPTH),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees the head slot within the same edge, so a full FIFO still
    // accepts a simultaneous push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_buffered_if.sv
// rtl/uart_buffered_if.sv - buffered RX/TX host interface beside uart_core
//
// Module uart_buffered_if
//   clk, rst_n                      : clock, asynchronous active-low reset
//   core_rx_data/valid/err          : received byte from uart_core, one-cycle valid
//   core_tx_busy                    : uart_core transmitter active
//   core_tx_data, core_tx_req       : byte and one-cycle start pulse to uart_core
//   host (uart_host_if.slave)       : RX FIFO head/pop/level/overrun, TX FIFO push/full/level, tx_active
module uart_buffered_if
    import uart_buf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] core_rx_data,
    input  logic              core_rx_valid,
    input  logic              core_rx_err,
    input  logic              core_tx_busy,
    output logic [DATA_W-1:0] core_tx_data,
    output logic              core_tx_req,
    uart_host_if.slave        host
);

    localparam int RX_LW = lvl_w(RX_DEPTH);
    localparam int TX_LW = lvl_w(TX_DEPTH);

    localparam logic [1:0] S_IDLE       = IDLE;
    localparam logic [1:0] S_REQ        = REQ;
    localparam logic [1:0] S_WAIT_START = WAIT_START;
    localparam logic [1:0] S_WAIT_DONE  = WAIT_DONE;

    // RX path: error tag travels in the MSB of each entry
    logic [DATA_W:0]   rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic [RX_LW-1:0]  rx_level;
    logic              ovr_q, ovr_d;
    logic              ovr_set;

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (core_rx_valid),
        .pop   (host.rx_pop),
        .wdata ({core_rx_err, core_rx_data}),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    // A full FIFO with a pop in the same cycle makes room, so no byte is lost.
    assign ovr_set = core_rx_valid && rx_full && !host.rx_pop;

    always_comb begin
        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (host.ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    assign host.rx_data     = rx_head[DATA_W-1:0];
    assign host.rx_data_err = rx_head[DATA_W];
    assign host.rx_avail    = !rx_empty;
    assign host.rx_level    = rx_level;
    assign host.rx_overrun  = ovr_q;

    // TX path
    logic [DATA_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic [TX_LW-1:0]  tx_level;
    logic              tx_pop;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (host.tx_push),
        .pop   (tx_pop),
        .wdata (host.tx_wdata),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    // The head byte is captured and popped on the IDLE->REQ edge; the
    // register then holds it until the core has finished with it.
    assign tx_pop = (state_q == S_IDLE) && !tx_empty;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    state_d   = S_REQ;
                    tx_data_d = tx_head;
                end
            end
            S_REQ: begin
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (core_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!core_tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_data_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            ovr_q     <= ovr_d;
        end
    end

    assign core_tx_data   = tx_data_q;
    assign core_tx_req    = (state_q == S_REQ);
    assign host.tx_full   = tx_full;
    assign host.tx_level  = tx_level;
    assign host.tx_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_buffered_if.sv
// tb/tb_uart_buffered_if.sv - self-checking bench for uart_buffered_if
module tb_uart_buffered_if;

    localparam int DATA_W   = 8;
    localparam int RX_DEPTH = 4;
    localparam int TX_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] core_rx_data;
    logic       core_rx_valid;
    logic       core_rx_err;
    logic       core_tx_busy = 1'b0;
    logic [7:0] core_tx_data;
    logic       core_tx_req;

    always #5 clk = ~clk;

    uart_host_if #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) host ();

    uart_buffered_if #(
        .DATA_W   (DATA_W),
        .RX_DEPTH (RX_DEPTH),
        .TX_DEPTH (TX_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_rx_data  (core_rx_data),
        .core_rx_valid (core_rx_valid),
        .core_rx_err   (core_rx_err),
        .core_tx_busy  (core_tx_busy),
        .core_tx_data  (core_tx_data),
        .core_tx_req   (core_tx_req),
        .host          (host)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core model: busy rises one cycle after the req pulse, stays high 10 cycles.
    bit         model_en = 1'b0;
    int         bcnt     = 0;
    logic [7:0] reqs[$];

    always @(negedge clk) begin
        if (!model_en) begin
            bcnt         = 0;
            core_tx_busy = 1'b0;
        end else if (core_tx_req) begin
            reqs.push_back(core_tx_data);
            bcnt = 11;
        end else if (bcnt > 0) begin
            bcnt--;
            core_tx_busy = (bcnt > 0);
        end
    end

    typedef struct {
        logic       v;
        logic       e;
        logic [7:0] d;
        logic       pop;
        logic       clr;
        int         lvl;
        logic       avail;
        logic [7:0] hd;
        logic       herr;
        logic       ovr;
    } rx_vec_t;

    rx_vec_t tbl[$];

    task automatic add(input logic v, input logic e, input logic [7:0] d, input logic pop,
                       input logic clr, input int lvl, input logic [7:0] hd,
                       input logic herr, input logic ovr);
        rx_vec_t r;
        r.v = v; r.e = e; r.d = d; r.pop = pop; r.clr = clr;
        r.lvl = lvl; r.avail = (lvl != 0); r.hd = hd; r.herr = herr; r.ovr = ovr;
        tbl.push_back(r);
    endtask

    task automatic clear_inputs();
        core_rx_valid = 1'b0;
        core_rx_err   = 1'b0;
        core_rx_data  = '0;
        host.rx_pop   = 1'b0;
        host.ovr_clr  = 1'b0;
        host.tx_push  = 1'b0;
        host.tx_wdata = '0;
    endtask

    task automatic wait_tx_idle(input int n_req, input string name);
        int cyc = 0;
        while (!(reqs.size() == n_req && !host.tx_active) && cyc < 600) begin
            step();
            cyc++;
        end
        chk({name, "_timeout"}, (cyc >= 600), 0);
    endtask

    logic [8:0] mq[$];
    bit         movr;
    logic [7:0] bytes[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) step();

        chk("rst_rx_level",  host.rx_level,   0);
        chk("rst_rx_avail",  host.rx_avail,   0);
        chk("rst_rx_data",   host.rx_data,    0);
        chk("rst_overrun",   host.rx_overrun, 0);
        chk("rst_tx_level",  host.tx_level,   0);
        chk("rst_tx_full",   host.tx_full,    0);
        chk("rst_tx_req",    core_tx_req,     0);
        chk("rst_tx_data",   core_tx_data,    0);
        chk("rst_tx_active", host.tx_active,  0);

        rst_n    = 1'b1;
        model_en = 1'b1;
        step();

        // RX table: fill/overrun/drain, full+pop+push, error tags, set-vs-clear.
        //   v  e  d      pop clr lvl hd     herr ovr
        add(1, 0, 8'h10, 0, 0, 1, 8'h10, 0, 0);
        add(1, 0, 8'h11, 0, 0, 2, 8'h10, 0, 0);
        add(1, 0, 8'h12, 0, 0, 3, 8'h10, 0, 0);
        add(1, 0, 8'h13, 0, 0, 4, 8'h10, 0, 0);
        add(1, 0, 8'h14, 0, 0, 4, 8'h10, 0, 1);
        add(0, 0, 8'h00, 1, 0, 3, 8'h11, 0, 1);
        add(0, 0, 8'h00, 1, 0, 2, 8'h12, 0, 1);
        add(0, 0, 8'h00, 1, 0, 1, 8'h13, 0, 1);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
        add(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        add(1, 0, 8'h20, 0, 0, 1, 8'h20, 0, 0);
        add(1, 0, 8'h21, 0, 0, 2, 8'h20, 0, 0);
        add(1, 0, 8'h22, 0, 0, 3, 8'h20, 0, 0);
        add(1, 0, 8'h23, 0, 0, 4, 8'h20, 0, 0);
        add(1, 0, 8'h24, 1, 0, 4, 8'h21, 0, 0);
        add(0, 0, 8'h00, 1, 0, 3, 8'h22, 0, 0);
        add(0, 0, 8'h00, 1, 0, 2, 8'h23, 0, 0);
        add(0, 0, 8'h00, 1, 0, 1, 8'h24, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        add(1, 1, 8'h55, 0, 0, 1, 8'h55, 1, 0);
        add(1, 0, 8'h66, 0, 0, 2, 8'h55, 1, 0);
        add(0, 0, 8'h00, 1, 0, 1, 8'h66, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        add(1, 0, 8'h30, 0, 0, 1, 8'h30, 0, 0);
        add(1, 0, 8'h31, 0, 0, 2, 8'h30, 0, 0);
        add(1, 0, 8'h32, 0, 0, 3, 8'h30, 0, 0);
        add(1, 0, 8'h33, 0, 0, 4, 8'h30, 0, 0);
        add(1, 0, 8'h34, 0, 1, 4, 8'h30, 0, 1);
        add(0, 0, 8'h00, 0, 1, 4, 8'h30, 0, 0);
        add(0, 0, 8'h00, 1, 0, 3, 8'h31, 0, 0);
        add(0, 0, 8'h00, 1, 0, 2, 8'h32, 0, 0);
        add(0, 0, 8'h00, 1, 0, 1, 8'h33, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);

        foreach (tbl[i]) begin
            core_rx_valid = tbl[i].v;
            core_rx_err   = tbl[i].e;
            core_rx_data  = tbl[i].d;
            host.rx_pop   = tbl[i].pop;
            host.ovr_clr  = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_level", i),   host.rx_level,    tbl[i].lvl);
            chk($sformatf("vec%0d_avail", i),   host.rx_avail,    tbl[i].avail);
            chk($sformatf("vec%0d_data", i),    host.rx_data,     tbl[i].hd);
            chk($sformatf("vec%0d_err", i),     host.rx_data_err, tbl[i].herr);
            chk($sformatf("vec%0d_overrun", i), host.rx_overrun,  tbl[i].ovr);
        end
        clear_inputs();

        // Random RX traffic against a queue model.
        mq.delete();
        movr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic       v, e, p, cl, set;
            logic [7:0] d;
            v  = ($urandom_range(0, 99) < 55);
            e  = $urandom_range(0, 1);
            d  = 8'($urandom);
            p  = ($urandom_range(0, 99) < 40);
            cl = ($urandom_range(0, 99) < 15);
            core_rx_valid = v;
            core_rx_err   = e;
            core_rx_data  = d;
            host.rx_pop   = p;
            host.ovr_clr  = cl;
            if (p && mq.size() > 0) void'(mq.pop_front());
            set = 1'b0;
            if (v) begin
                if (mq.size() < RX_DEPTH) mq.push_back({e, d});
                else set = 1'b1;
            end
            if (set) movr = 1'b1;
            else if (cl) movr = 1'b0;
            step();
            chk("rnd_level",   host.rx_level,    mq.size());
            chk("rnd_avail",   host.rx_avail,    mq.size() > 0);
            chk("rnd_data",    host.rx_data,     (mq.size() > 0) ? mq[0][7:0] : 8'h00);
            chk("rnd_err",     host.rx_data_err, (mq.size() > 0) ? mq[0][8] : 1'b0);
            chk("rnd_overrun", host.rx_overrun,  movr);
        end
        clear_inputs();
        step();

        // TX: 0x41 then 0x42, push-to-req latency and ordering.
        reqs.delete();
        host.tx_push  = 1'b1;
        host.tx_wdata = 8'h41;
        step();
        chk("tx1_level", host.tx_level,  1);
        chk("tx1_req",   core_tx_req,    0);
        chk("tx1_act",   host.tx_active, 0);
        host.tx_wdata = 8'h42;
        step();
        chk("tx2_level", host.tx_level,  1);
        chk("tx2_req",   core_tx_req,    1);
        chk("tx2_data",  core_tx_data,   8'h41);
        chk("tx2_act",   host.tx_active, 1);
        clear_inputs();
        step();
        chk("tx3_req",   core_tx_req,    0);
        chk("tx3_data",  core_tx_data,   8'h41);
        wait_tx_idle(2, "tx_pair");
        chk("tx_pair_n",     reqs.size(), 2);
        chk("tx_pair_b0",    (reqs.size() > 0) ? reqs[0] : 8'hxx, 8'h41);
        chk("tx_pair_b1",    (reqs.size() > 1) ? reqs[1] : 8'hxx, 8'h42);
        chk("tx_pair_level", host.tx_level, 0);

        // TX random batches; from idle, DEPTH queued plus one in flight fit.
        for (int b = 0; b < 4; b++) begin
            int n;
            int keep;
            n = (b == 0) ? 6 : $urandom_range(1, 6);
            keep = (n > TX_DEPTH + 1) ? TX_DEPTH + 1 : n;
            reqs.delete();
            bytes.delete();
            for (int k = 0; k < n; k++) begin
                logic [7:0] x;
                x = 8'($urandom);
                bytes.push_back(x);
                host.tx_push  = 1'b1;
                host.tx_wdata = x;
                step();
                if (b == 0 && k == 4) begin
                    chk("txb_full",  host.tx_full,  1);
                    chk("txb_level", host.tx_level, 4);
                end
                if (b == 0 && k == 5) begin
                    chk("txb_drop_level", host.tx_level, 4);
                end
            end
            clear_inputs();
            wait_tx_idle(keep, $sformatf("txb%0d", b));
            repeat (30) step();
            chk($sformatf("txb%0d_n", b), reqs.size(), keep);
            for (int k = 0; k < keep; k++) begin
                chk($sformatf("txb%0d_b%0d", b, k),
                    (k < reqs.size()) ? reqs[k] : 8'hxx, bytes[k]);
            end
        end

        // Reset during WAIT_DONE with two bytes queued.
        reqs.delete();
        for (int k = 0; k < 3; k++) begin
            host.tx_push  = 1'b1;
            host.tx_wdata = 8'hA0 + 8'(k);
            step();
        end
        clear_inputs();
        begin
            int cyc = 0;
            while (!core_tx_busy && cyc < 50) begin
                step();
                cyc++;
            end
            chk("rstw_timeout", (cyc >= 50), 0);
        end
        repeat (2) step();
        chk("pre_rst_level", host.tx_level,  2);
        chk("pre_rst_act",   host.tx_active, 1);
        rst_n    = 1'b0;
        model_en = 1'b0;
        #1;
        chk("mid_rst_level", host.tx_level,  0);
        chk("mid_rst_req",   core_tx_req,    0);
        chk("mid_rst_act",   host.tx_active, 0);
        chk("mid_rst_data",  core_tx_data,   0);
        repeat (2) step();
        rst_n    = 1'b1;
        model_en = 1'b1;
        repeat (40) step();
        chk("post_rst_nreq",  reqs.size(),    1);
        chk("post_rst_act",   host.tx_active, 0);
        chk("post_rst_level", host.tx_level,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
